// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive path: default FIFO depth and the
// bit layout of the status word exposed to the bus slave.
package uart_rx_fifo_pkg;

    // log2 of the default receive FIFO depth (16 entries)
    localparam int unsigned UART_FIFO_DEPTH_W = 4;

    // Status register bit positions
    localparam int unsigned STAT_VALID_BIT    = 0;
    localparam int unsigned STAT_FULL_BIT     = 1;
    localparam int unsigned STAT_OVERFLOW_BIT = 2;
    localparam int unsigned STAT_FRAMING_BIT  = 3;

    // Assemble the 4-bit status word from the individual FIFO flags
    function automatic logic [3:0] pack_status(input logic valid,
                                               input logic full,
                                               input logic overflow,
                                               input logic framing_err);
        logic [3:0] s;
        s                    = 4'h0;
        s[STAT_VALID_BIT]    = valid;
        s[STAT_FULL_BIT]     = full;
        s[STAT_OVERFLOW_BIT] = overflow;
        s[STAT_FRAMING_BIT]  = framing_err;
        return s;
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// 2^ADDR_W x WIDTH storage with synchronous write and asynchronous read.
// Shared by the RX FIFO and intended for the TX-side FIFO as well.
module uart_fifo_ram #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned WIDTH  = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is not reset: contents are only meaningful behind valid pointers
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational read gives the FIFO its fall-through head
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the byte-level UART receiver: drains the UART holding
// register with a one-cycle acknowledge strobe, queues bytes in an FWFT FIFO
// and reports level, sticky overflow/framing flags and a threshold interrupt.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_W = UART_FIFO_DEPTH_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [7:0]         uart_data_i,
    input  logic               uart_ready_i,
    input  logic               uart_err_i,
    output logic               uart_rd_o,
    input  logic               pop_i,
    output logic [7:0]         data_o,
    output logic               valid_o,
    output logic [DEPTH_W:0]   level_o,
    output logic               full_o,
    input  logic               clr_i,
    input  logic [DEPTH_W:0]   thresh_i,
    output logic               overflow_o,
    output logic               framing_err_o,
    output logic               irq_o
);

    localparam int unsigned LVL_W = DEPTH_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(2 ** DEPTH_W);

    logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               rd_strobe_q, rd_strobe_d;
    logic               overflow_q, overflow_d;
    logic               framing_q, framing_d;
    logic               irq_q, irq_d;

    logic               cap;
    logic               full;
    logic               empty;
    logic               do_pop;
    logic               do_push;
    logic               drop;
    logic [7:0]         ram_rdata;

    // Capture/ack decisions, pointer and level updates, sticky flags and irq
    always_comb begin
        // The UART flag drops one cycle after our strobe, so block re-capture
        // while the strobe is high.
        cap     = (uart_ready_i | uart_err_i) & ~rd_strobe_q;
        full    = (level_q == DEPTH_LVL);
        empty   = (level_q == '0);
        do_pop  = pop_i & ~empty & ~clr_i;
        do_push = cap & uart_ready_i & ~clr_i & (~full | do_pop);
        drop    = cap & uart_ready_i & ~clr_i & full & ~do_pop;

        // Every capture is acknowledged, even one discarded by a flush
        rd_strobe_d = cap;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        framing_d  = framing_q;

        if (clr_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            framing_d  = 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + DEPTH_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + DEPTH_W'(1);
            end
            if (do_push && !do_pop) begin
                level_d = level_q + LVL_W'(1);
            end else if (do_pop && !do_push) begin
                level_d = level_q - LVL_W'(1);
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
            if (cap && uart_err_i) begin
                framing_d = 1'b1;
            end
        end

        // Interrupt follows the post-update state so it tracks level exactly
        irq_d = ((thresh_i != '0) && (level_d >= thresh_i)) | overflow_d | framing_d;
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rd_strobe_q <= 1'b0;
            overflow_q  <= 1'b0;
            framing_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rd_strobe_q <= rd_strobe_d;
            overflow_q  <= overflow_d;
            framing_q   <= framing_d;
            irq_q       <= irq_d;
        end
    end

    uart_fifo_ram #(
        .ADDR_W (DEPTH_W),
        .WIDTH  (8)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (do_push),
        .waddr_i (wr_ptr_q),
        .wdata_i (uart_data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    assign uart_rd_o     = rd_strobe_q;
    assign valid_o       = ~empty;
    assign full_o        = full;
    assign level_o       = level_q;
    // Head reads as zero while empty so reset/flush leave a clean bus value
    assign data_o        = empty ? 8'h00 : ram_rdata;
    assign overflow_o    = overflow_q;
    assign framing_err_o = framing_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue scoreboard holds accepted
// bytes, popped head values are compared against it in order.
module tb_uart_rx_fifo;

    localparam int DW = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [7:0]    uart_data_i;
    logic          uart_ready_i;
    logic          uart_err_i;
    logic          uart_rd_o;
    logic          pop_i;
    logic [7:0]    data_o;
    logic          valid_o;
    logic [DW:0]   level_o;
    logic          full_o;
    logic          clr_i;
    logic [DW:0]   thresh_i;
    logic          overflow_o;
    logic          framing_err_o;
    logic          irq_o;

    int total = 0;
    int bad   = 0;
    int rd_cnt = 0;
    logic [7:0] exp_q [$];

    uart_rx_fifo #(.DEPTH_W(DW)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .uart_data_i   (uart_data_i),
        .uart_ready_i  (uart_ready_i),
        .uart_err_i    (uart_err_i),
        .uart_rd_o     (uart_rd_o),
        .pop_i         (pop_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .level_o       (level_o),
        .full_o        (full_o),
        .clr_i         (clr_i),
        .thresh_i      (thresh_i),
        .overflow_o    (overflow_o),
        .framing_err_o (framing_err_o),
        .irq_o         (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Count acknowledge pulses, sampled away from the active edge
    always @(negedge clk_i) if (uart_rd_o === 1'b1) rd_cnt++;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    // UART model: holding register raised, strobe expected, flag dropped
    task automatic send_byte(input logic [7:0] b, input bit accept);
        uart_data_i  = b;
        uart_ready_i = 1'b1;
        tick();
        check_val("rd_strobe", uart_rd_o, 1);
        uart_ready_i = 1'b0;
        tick();
        check_val("rd_single", uart_rd_o, 0);
        if (accept) exp_q.push_back(b);
        $display("send %02h accept=%0d level=%0d", b, accept, level_o);
    endtask

    task automatic pop_one();
        logic [7:0] e;
        check_val("pop_valid", valid_o, 1);
        if (exp_q.size() == 0) begin
            check_val("sb_empty", 1, 0);
            e = 8'h00;
        end else begin
            e = exp_q.pop_front();
        end
        check_val("pop_data", data_o, e);
        $display("pop  %02h expect %02h", data_o, e);
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
    endtask

    task automatic flush();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int c0;
        rst_ni = 1'b0; uart_data_i = 8'h00; uart_ready_i = 1'b0; uart_err_i = 1'b0;
        pop_i = 1'b0; clr_i = 1'b0; thresh_i = '0;
        tick(); tick();
        check_val("rst_level", level_o, 0);
        check_val("rst_valid", valid_o, 0);
        check_val("rst_data", data_o, 8'h00);
        check_val("rst_rd", uart_rd_o, 0);
        check_val("rst_irq", irq_o, 0);
        rst_ni = 1'b1;
        tick();

        // Single byte with ready held two cycles: exactly one strobe
        c0 = rd_cnt;
        uart_data_i = 8'h55; uart_ready_i = 1'b1;
        tick(); tick();
        uart_ready_i = 1'b0;
        tick();
        exp_q.push_back(8'h55);
        check_val("one_pulse", rd_cnt - c0, 1);
        check_val("b1_level", level_o, 1);
        check_val("b1_full", full_o, 0);
        pop_one();
        check_val("b1_level0", level_o, 0);
        check_val("b1_valid0", valid_o, 0);

        // Fill to 16, then overflow
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
        check_val("fill_full", full_o, 1);
        check_val("fill_level", level_o, 16);
        check_val("fill_ovf0", overflow_o, 0);
        send_byte(8'hAA, 1'b0);
        check_val("ovf_set", overflow_o, 1);
        check_val("ovf_irq", irq_o, 1);
        check_val("ovf_level", level_o, 16);
        for (int i = 0; i < 16; i++) pop_one();
        check_val("drain_valid", valid_o, 0);
        flush();
        check_val("clr_ovf", overflow_o, 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b1);
        check_val("full2", full_o, 1);
        check_val("pp_head", data_o, exp_q[0]);
        void'(exp_q.pop_front());
        uart_data_i = 8'hBB; uart_ready_i = 1'b1; pop_i = 1'b1;
        tick();
        pop_i = 1'b0; uart_ready_i = 1'b0;
        check_val("pp_rd", uart_rd_o, 1);
        exp_q.push_back(8'hBB);
        tick();
        check_val("pp_level", level_o, 16);
        check_val("pp_ovf", overflow_o, 0);
        for (int i = 0; i < 16; i++) pop_one();
        check_val("pp_empty", level_o, 0);

        // Framing error alone
        send_byte(8'h21, 1'b1);
        send_byte(8'h22, 1'b1);
        uart_err_i = 1'b1;
        tick();
        check_val("err_rd", uart_rd_o, 1);
        uart_err_i = 1'b0;
        tick();
        check_val("err_flag", framing_err_o, 1);
        check_val("err_level", level_o, 2);
        check_val("err_irq", irq_o, 1);
        flush();
        check_val("clr_fe", framing_err_o, 0);
        check_val("clr_level", level_o, 0);
        check_val("clr_valid", valid_o, 0);
        check_val("clr_irq", irq_o, 0);

        // Threshold interrupt
        thresh_i = 5'd4;
        for (int i = 0; i < 3; i++) send_byte(8'(8'h40 + i), 1'b1);
        check_val("thr_below", irq_o, 0);
        send_byte(8'h43, 1'b1);
        check_val("thr_rise", irq_o, 1);
        pop_one();
        check_val("thr_fall", irq_o, 0);
        check_val("thr_level", level_o, 3);
        for (int i = 0; i < 3; i++) pop_one();
        thresh_i = '0;

        // Pop while empty is ignored
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
        check_val("under_level", level_o, 0);
        check_val("under_valid", valid_o, 0);

        // Reset mid-stream with a byte pending
        for (int i = 0; i < 3; i++) send_byte(8'(8'h30 + i), 1'b1);
        uart_data_i = 8'h3C; uart_ready_i = 1'b1;
        #2 rst_ni = 1'b0;
        #1;
        check_val("arst_level", level_o, 0);
        check_val("arst_valid", valid_o, 0);
        check_val("arst_rd", uart_rd_o, 0);
        check_val("arst_data", data_o, 8'h00);
        exp_q.delete();
        tick(); tick();
        check_val("arst_hold_rd", uart_rd_o, 0);
        rst_ni = 1'b1;
        tick();
        check_val("post_rd", uart_rd_o, 1);
        uart_ready_i = 1'b0;
        exp_q.push_back(8'h3C);
        tick();
        check_val("post_level", level_o, 1);
        pop_one();
        check_val("post_empty", level_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
